// File: rtl/reqwalker_master.sv
// reqwalker_master: debounced push button that starts a Wishbone walk.
// Each accepted press issues one write, then polls a status register with
// reads separated by idle gaps until the walker reports idle (data[3:0]==0).
// Missing acks (timeout) and bus errors abort the walk and raise a sticky error.
module reqwalker_master #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned POLL_GAP        = 4,
  parameter int unsigned ACK_TIMEOUT     = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_btn,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic        o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(POLL_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_ACK,
    S_GAP,
    S_RD,
    S_RD_ACK
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pend_q, pend_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              press;
  logic              abort;
  logic              rd_idle;
  logic              unused_rd_hi;

  assign rd_idle      = (i_wb_data[3:0] == 4'h0);
  assign unused_rd_hi = ^i_wb_data[31:4];

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES differing samples in a row
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_d  = sync2_q;
        press = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Walk sequencing: next state, counters, pending press and error flag
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    tmo_d   = '0;
    pend_d  = pend_q;
    err_d   = err_q;
    done_d  = 1'b0;
    abort   = 1'b0;

    if (press && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_WR;
          err_d   = 1'b0;
        end
      end
      S_WR: begin
        if (i_wb_err) begin
          abort = 1'b1;
        end else if (!i_wb_stall) begin
          state_d = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        if (i_wb_err) begin
          abort = 1'b1;
        end else if (i_wb_ack) begin
          state_d = S_GAP;
        end else if (tmo_q == TMO_MAX) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = S_RD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RD: begin
        if (!i_wb_stall) begin
          state_d = S_RD_ACK;
        end
      end
      S_RD_ACK: begin
        if (i_wb_err) begin
          abort = 1'b1;
        end else if (i_wb_ack) begin
          if (!rd_idle) begin
            state_d = S_GAP;
          end else begin
            done_d = 1'b1;
            // a press landing in the completion cycle is treated as pending
            if (pend_q || press) begin
              state_d = S_WR;
              pend_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (tmo_q == TMO_MAX) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      pend_d  = 1'b0;
    end
  end

  // Bus and status outputs are registered decodes of the next state
  always_comb begin
    cyc_d  = (state_d == S_WR) || (state_d == S_WR_ACK) ||
             (state_d == S_RD) || (state_d == S_RD_ACK);
    stb_d  = (state_d == S_WR) || (state_d == S_RD);
    we_d   = (state_d == S_WR);
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      pend_q   <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      pend_q   <= pend_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = 1'b0;
  assign o_wb_data = '0;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule
